guess_entry: RTL and testbench
==============================

GUESS_ENTRY -- requirements
Module: guess_entry

Interface
REQ-001 Parameter KEY_BACK, default 4'hD: key code that deletes the last entered digit.
REQ-002 Parameter KEY_CLEAR, default 4'hE: key code that empties the entry buffer.
REQ-003 Parameter KEY_ENTER, default 4'hF: key code that submits the buffer.
REQ-004 Parameter ALLOW_REPEAT, default 0: 1 accepts repeated digits; 0 rejects a submission containing them.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 key_code  in  4  key from keypad decoder: 0-9 digits, A-F function keys.
REQ-008 key_valid  in  1  one-cycle strobe qualifying key_code.
REQ-009 oNum1, oNum2, oNum3  out  4 each  last submitted digits; oNum1 is the first digit keyed.
REQ-010 oNumRdy  out  1  one-cycle pulse; oNum1-3 are valid in the same cycle.
REQ-011 oDig1, oDig2, oDig3  out  4 each  live entry buffer for display; unused slots read 4'h0.
REQ-012 oCnt  out  2  number of digits in the buffer, 0-3.
REQ-013 oErr  out  1  one-cycle pulse on a rejected key or submission.
REQ-014 oSubCnt  out  8  count of accepted submissions; saturates at 255.

Function
REQ-015 FSM states: ENTRY and SUBMIT; the FSM idles in ENTRY.
REQ-016 ENTRY behaviour:
- Sampling: key_valid is sampled every rising edge; a key takes effect at that edge.
- Effect latency: oDig/oCnt reflect the key in the next cycle.
- Digit key (0-9), oCnt<3: digit is written to slot oCnt+1; oCnt increments.
REQ-017 Digit key with oCnt==3: buffer unchanged; oErr pulses in the next cycle.
REQ-018 KEY_BACK behaviour:
- oCnt>0: clears the highest occupied slot to 0 and decrements oCnt.
- oCnt==0: no-op, no oErr.
REQ-019 KEY_CLEAR: all slots go to 0 and oCnt goes to 0; no oErr.
REQ-020 KEY_ENTER with oCnt<3: buffer unchanged; oErr pulses in the next cycle.
REQ-021 KEY_ENTER with oCnt==3 and ALLOW_REPEAT==0 and any two digits equal: buffer unchanged; oErr pulses in the next cycle.
REQ-022 KEY_ENTER with oCnt==3 and the digits valid:
- Outputs: oNum1-3 load the buffer, and oNumRdy=1 in the next cycle.
- Buffer: cleared at the same edge.
- oSubCnt: increments.
- FSM: moves to SUBMIT.
REQ-023 SUBMIT lasts exactly one cycle, then returns to ENTRY; any key_valid in SUBMIT is ignored and produces no oErr.
REQ-024 Keys A-C, other than the configured function keys: ignored, no oErr.
REQ-025 oNum1-3 hold their values until the next accepted submission.
REQ-026 oNumRdy and oErr are registered, never both high, and never high for more than one cycle per event.
REQ-027 oSubCnt at 255 stays at 255; submissions are still accepted.

Reset
REQ-028 Reset assertion immediately (asynchronously) sets:
- the FSM to ENTRY;
- oNum1-3, oDig1-3, oCnt, oSubCnt to 0;
- oNumRdy and oErr to 0.
REQ-029 Reset mid-entry or during SUBMIT discards the buffer; no oNumRdy is emitted after release.
REQ-030 Deassertion is synchronised externally; the first key is accepted at the first edge after release.

Structure
REQ-031 The shared game package holds the digit width (4), the digit count (3), the KEY_* default codes, and the FSM state encodings.
REQ-032 One sub-module, digit_distinct, SHALL be combinational: three 4-bit digits in, one "all distinct" flag out.
REQ-033 No other sub-modules; the FSM, buffer and output registers live in guess_entry.

Verification
REQ-034 Reset, then keys 1,2,3,F -> one cycle later oNumRdy=1 for one cycle with oNum1..3=1,2,3; oCnt=0; oSubCnt=1.
REQ-035 Keys 4,4,5,F -> oErr single pulse; oCnt=3; oDig=4,4,5; no oNumRdy; oNum unchanged. Same keys with ALLOW_REPEAT=1 -> accepted.
REQ-036 Keys 7,8,D,9,F -> oNum=7,9,0 rejected (oCnt=2, oErr); then 6,F -> oNumRdy with 7,9,6.
REQ-037 Keys 1,2,3,4 -> oErr on the fourth key; oDig=1,2,3. Then E -> oCnt=0, all oDig=0.
REQ-038 Submit 3,2,1 with key 5 strobed in the SUBMIT cycle -> 5 ignored; oCnt=0; no oErr.
REQ-039 Reset asserted between the second and third digit, then keys 9,8,7,F after release -> oNumRdy only for 9,8,7; oSubCnt=1.

Source files
------------

// File: rtl/guess_entry_pkg.sv
// Purpose : shared definitions for the guess-entry keypad block (widths, key codes, FSM encodings).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package guess_entry_pkg;

    localparam int DIG_W     = 4;   // bits per digit / key code
    localparam int DIG_N     = 3;   // digits per guess
    localparam int CNT_W     = 2;   // width of the buffer occupancy count
    localparam int SUB_CNT_W = 8;   // width of the submission counter

    localparam logic [CNT_W-1:0]     CNT_FULL    = 2'd3;
    localparam logic [SUB_CNT_W-1:0] SUB_CNT_MAX = 8'hFF;

    localparam logic [DIG_W-1:0] KEY_BACK_DEF  = 4'hD;
    localparam logic [DIG_W-1:0] KEY_CLEAR_DEF = 4'hE;
    localparam logic [DIG_W-1:0] KEY_ENTER_DEF = 4'hF;

    typedef enum logic {
        ST_ENTRY  = 1'b0,
        ST_SUBMIT = 1'b1
    } state_t;

    // Codes 0-9 are digits; A-F are function keys.
    function automatic logic is_digit(input logic [DIG_W-1:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/digit_distinct.sv
// Purpose : flags whether three digits are pairwise distinct.
// Latency : combinational, zero cycles.
// Backpressure: none (pure function of inputs).
// Ports   : dig1..dig3 in (DIG_W each), all_distinct out (1).
module digit_distinct
    import guess_entry_pkg::*;
(
    input  logic [DIG_W-1:0] dig1,
    input  logic [DIG_W-1:0] dig2,
    input  logic [DIG_W-1:0] dig3,
    output logic             all_distinct
);

    assign all_distinct = (dig1 != dig2) && (dig1 != dig3) && (dig2 != dig3);

endmodule

// File: rtl/guess_entry.sv
// Purpose : keypad entry buffer for a 3-digit guess with back/clear/enter editing and submission.
// Latency : every key takes effect at the sampling edge; outputs reflect it in the next cycle.
// Backpressure: none; keys strobed during the one-cycle SUBMIT state are dropped silently.
// Ports   : clk, reset (async active-low), key_code/key_valid in;
//           oNum1-3/oNumRdy (submitted guess), oDig1-3/oCnt (live buffer),
//           oErr (rejected key pulse), oSubCnt (saturating submission count) out.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter logic [DIG_W-1:0] KEY_BACK     = KEY_BACK_DEF,
    parameter logic [DIG_W-1:0] KEY_CLEAR    = KEY_CLEAR_DEF,
    parameter logic [DIG_W-1:0] KEY_ENTER    = KEY_ENTER_DEF,
    parameter bit               ALLOW_REPEAT = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIG_W-1:0]     key_code,
    input  logic                 key_valid,
    output logic [DIG_W-1:0]     oNum1,
    output logic [DIG_W-1:0]     oNum2,
    output logic [DIG_W-1:0]     oNum3,
    output logic                 oNumRdy,
    output logic [DIG_W-1:0]     oDig1,
    output logic [DIG_W-1:0]     oDig2,
    output logic [DIG_W-1:0]     oDig3,
    output logic [CNT_W-1:0]     oCnt,
    output logic                 oErr,
    output logic [SUB_CNT_W-1:0] oSubCnt
);

    state_t                 state_q;
    state_t                 state_d;
    logic [DIG_W-1:0]       dig1_q, dig2_q, dig3_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DIG_W-1:0]       num1_q, num2_q, num3_q;
    logic                   num_rdy_q;
    logic                   err_q;
    logic [SUB_CNT_W-1:0]   sub_cnt_q;
    logic                   all_distinct;

    // One-hot key actions decoded from the current state and key.
    logic act_push, act_back, act_clear, act_submit, act_err;

    digit_distinct u_digit_distinct (
        .dig1         (dig1_q),
        .dig2         (dig2_q),
        .dig3         (dig3_q),
        .all_distinct (all_distinct)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ENTRY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SUBMIT is a single-cycle excursion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTRY:  if (act_submit) state_d = ST_SUBMIT;
            ST_SUBMIT: state_d = ST_ENTRY;
        endcase
    end

    // Output/action logic. Function keys are matched before the digit range so
    // a parameterised function code always wins over a digit interpretation.
    always_comb begin
        act_push   = 1'b0;
        act_back   = 1'b0;
        act_clear  = 1'b0;
        act_submit = 1'b0;
        act_err    = 1'b0;
        if (state_q == ST_ENTRY && key_valid) begin
            if (key_code == KEY_ENTER) begin
                if (cnt_q != CNT_FULL || (!ALLOW_REPEAT && !all_distinct)) begin
                    act_err = 1'b1;
                end else begin
                    act_submit = 1'b1;
                end
            end else if (key_code == KEY_BACK) begin
                act_back = (cnt_q != '0);
            end else if (key_code == KEY_CLEAR) begin
                act_clear = 1'b1;
            end else if (is_digit(key_code)) begin
                if (cnt_q == CNT_FULL) begin
                    act_err = 1'b1;
                end else begin
                    act_push = 1'b1;
                end
            end
        end
    end

    // Entry buffer: slots fill in key order, back clears the highest occupied slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dig1_q <= '0;
            dig2_q <= '0;
            dig3_q <= '0;
            cnt_q  <= '0;
        end else if (act_clear || act_submit) begin
            dig1_q <= '0;
            dig2_q <= '0;
            dig3_q <= '0;
            cnt_q  <= '0;
        end else if (act_push) begin
            case (cnt_q)
                2'd0:    dig1_q <= key_code;
                2'd1:    dig2_q <= key_code;
                default: dig3_q <= key_code;
            endcase
            cnt_q <= cnt_q + 2'd1;
        end else if (act_back) begin
            case (cnt_q)
                2'd1:    dig1_q <= '0;
                2'd2:    dig2_q <= '0;
                default: dig3_q <= '0;
            endcase
            cnt_q <= cnt_q - 2'd1;
        end
    end

    // Submitted guess, status pulses and saturating submission counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num1_q    <= '0;
            num2_q    <= '0;
            num3_q    <= '0;
            num_rdy_q <= 1'b0;
            err_q     <= 1'b0;
            sub_cnt_q <= '0;
        end else begin
            num_rdy_q <= act_submit;
            err_q     <= act_err;
            if (act_submit) begin
                num1_q <= dig1_q;
                num2_q <= dig2_q;
                num3_q <= dig3_q;
                if (sub_cnt_q != SUB_CNT_MAX) begin
                    sub_cnt_q <= sub_cnt_q + 8'd1;
                end
            end
        end
    end

    assign oNum1   = num1_q;
    assign oNum2   = num2_q;
    assign oNum3   = num3_q;
    assign oNumRdy = num_rdy_q;
    assign oDig1   = dig1_q;
    assign oDig2   = dig2_q;
    assign oDig3   = dig3_q;
    assign oCnt    = cnt_q;
    assign oErr    = err_q;
    assign oSubCnt = sub_cnt_q;

endmodule

// File: tb/tb_guess_entry.sv
// Purpose : directed self-checking bench for guess_entry (default and ALLOW_REPEAT=1 instances).
// Latency : keys driven on the falling edge, results sampled on the following falling edge.
// Backpressure: n/a.
module tb_guess_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;

    // ALLOW_REPEAT = 0 instance
    logic [3:0] num1, num2, num3, dig1, dig2, dig3;
    logic       num_rdy, err;
    logic [1:0] cnt;
    logic [7:0] sub_cnt;

    // ALLOW_REPEAT = 1 instance
    logic [3:0] r_num1, r_num2, r_num3, r_dig1, r_dig2, r_dig3;
    logic       r_num_rdy, r_err;
    logic [1:0] r_cnt;
    logic [7:0] r_sub_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    guess_entry u_dut (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .oNum1(num1), .oNum2(num2), .oNum3(num3), .oNumRdy(num_rdy),
        .oDig1(dig1), .oDig2(dig2), .oDig3(dig3), .oCnt(cnt),
        .oErr(err), .oSubCnt(sub_cnt)
    );

    guess_entry #(.ALLOW_REPEAT(1'b1)) u_dut_rep (
        .clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
        .oNum1(r_num1), .oNum2(r_num2), .oNum3(r_num3), .oNumRdy(r_num_rdy),
        .oDig1(r_dig1), .oDig2(r_dig2), .oDig3(r_dig3), .oCnt(r_cnt),
        .oErr(r_err), .oSubCnt(r_sub_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle key strobe; returns on the falling edge after the sampling edge.
    task automatic key(input logic [3:0] k);
        @(negedge clk);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state (asynchronous, checked while held)
        #1;
        check("rst_rdy",    {31'd0, num_rdy}, 32'd0);
        check("rst_err",    {31'd0, err},     32'd0);
        check("rst_cnt",    {30'd0, cnt},     32'd0);
        check("rst_subcnt", {24'd0, sub_cnt}, 32'd0);
        check("rst_num",    {20'd0, num1, num2, num3}, 32'h000);
        check("rst_dig",    {20'd0, dig1, dig2, dig3}, 32'h000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Basic submission 1,2,3,F
        key(4'h1); key(4'h2); key(4'h3);
        check("fill_cnt", {30'd0, cnt}, 32'd3);
        check("fill_dig", {20'd0, dig1, dig2, dig3}, 32'h123);
        key(4'hF);
        check("sub1_rdy",    {31'd0, num_rdy}, 32'd1);
        check("sub1_num",    {20'd0, num1, num2, num3}, 32'h123);
        check("sub1_cnt",    {30'd0, cnt}, 32'd0);
        check("sub1_dig",    {20'd0, dig1, dig2, dig3}, 32'h000);
        check("sub1_subcnt", {24'd0, sub_cnt}, 32'd1);
        check("sub1_err",    {31'd0, err}, 32'd0);
        @(negedge clk);
        check("sub1_rdy_drop", {31'd0, num_rdy}, 32'd0);
        check("sub1_num_hold", {20'd0, num1, num2, num3}, 32'h123);

        // Repeated digits 4,4,5,F: rejected by default, accepted with ALLOW_REPEAT
        key(4'h4); key(4'h4); key(4'h5); key(4'hF);
        check("rep_err",     {31'd0, err}, 32'd1);
        check("rep_rdy",     {31'd0, num_rdy}, 32'd0);
        check("rep_cnt",     {30'd0, cnt}, 32'd3);
        check("rep_dig",     {20'd0, dig1, dig2, dig3}, 32'h445);
        check("rep_num",     {20'd0, num1, num2, num3}, 32'h123);
        check("rep_a_rdy",   {31'd0, r_num_rdy}, 32'd1);
        check("rep_a_err",   {31'd0, r_err}, 32'd0);
        check("rep_a_num",   {20'd0, r_num1, r_num2, r_num3}, 32'h445);
        check("rep_a_subcnt", {24'd0, r_sub_cnt}, 32'd2);
        @(negedge clk);
        check("rep_err_drop", {31'd0, err}, 32'd0);
        key(4'hE);
        check("clr_cnt", {30'd0, cnt}, 32'd0);
        check("clr_dig", {20'd0, dig1, dig2, dig3}, 32'h000);
        check("clr_err", {31'd0, err}, 32'd0);

        // Back on empty buffer and unassigned function key: silent no-ops
        key(4'hD);
        check("back_empty_err", {31'd0, err}, 32'd0);
        check("back_empty_cnt", {30'd0, cnt}, 32'd0);
        key(4'h5); key(4'hA);
        check("keyA_err", {31'd0, err}, 32'd0);
        check("keyA_cnt", {30'd0, cnt}, 32'd1);
        check("keyA_dig", {20'd0, dig1, dig2, dig3}, 32'h500);
        key(4'hE);

        // Backspace editing 7,8,D,9,F then 6,F
        key(4'h7); key(4'h8); key(4'hD);
        check("back_cnt", {30'd0, cnt}, 32'd1);
        check("back_dig", {20'd0, dig1, dig2, dig3}, 32'h700);
        key(4'h9); key(4'hF);
        check("short_err", {31'd0, err}, 32'd1);
        check("short_rdy", {31'd0, num_rdy}, 32'd0);
        check("short_cnt", {30'd0, cnt}, 32'd2);
        check("short_dig", {20'd0, dig1, dig2, dig3}, 32'h790);
        key(4'h6); key(4'hF);
        check("edit_rdy",    {31'd0, num_rdy}, 32'd1);
        check("edit_num",    {20'd0, num1, num2, num3}, 32'h796);
        check("edit_subcnt", {24'd0, sub_cnt}, 32'd2);

        // Overflow key 1,2,3,4 then clear
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_cnt", {30'd0, cnt}, 32'd3);
        check("ovf_dig", {20'd0, dig1, dig2, dig3}, 32'h123);
        key(4'hE);
        check("ovf_clr_cnt", {30'd0, cnt}, 32'd0);
        check("ovf_clr_dig", {20'd0, dig1, dig2, dig3}, 32'h000);
        check("ovf_clr_err", {31'd0, err}, 32'd0);

        // Key strobed during the SUBMIT cycle is dropped
        key(4'h3); key(4'h2); key(4'h1); key(4'hF);
        check("subk_rdy", {31'd0, num_rdy}, 32'd1);
        check("subk_num", {20'd0, num1, num2, num3}, 32'h321);
        key_code  = 4'h5;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("subk_cnt",    {30'd0, cnt}, 32'd0);
        check("subk_err",    {31'd0, err}, 32'd0);
        check("subk_rdy2",   {31'd0, num_rdy}, 32'd0);
        check("subk_subcnt", {24'd0, sub_cnt}, 32'd3);

        // Asynchronous reset mid-entry
        key(4'h1); key(4'h2);
        #2 reset = 1'b0;
        #1;
        check("amid_cnt",    {30'd0, cnt}, 32'd0);
        check("amid_dig",    {20'd0, dig1, dig2, dig3}, 32'h000);
        check("amid_subcnt", {24'd0, sub_cnt}, 32'd0);
        check("amid_num",    {20'd0, num1, num2, num3}, 32'h000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("amid_rel_rdy", {31'd0, num_rdy}, 32'd0);
        key(4'h9); key(4'h8); key(4'h7); key(4'hF);
        check("amid_sub_rdy",    {31'd0, num_rdy}, 32'd1);
        check("amid_sub_num",    {20'd0, num1, num2, num3}, 32'h987);
        check("amid_sub_subcnt", {24'd0, sub_cnt}, 32'd1);

        // Reset landing in the SUBMIT cycle
        key(4'h1); key(4'h2); key(4'h3); key(4'hF);
        #2 reset = 1'b0;
        #1;
        check("asub_rdy",    {31'd0, num_rdy}, 32'd0);
        check("asub_subcnt", {24'd0, sub_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("asub_rel_rdy", {31'd0, num_rdy}, 32'd0);
        check("asub_rel_cnt", {30'd0, cnt}, 32'd0);

        // Submission counter saturation
        do_reset();
        for (int i = 0; i < 255; i++) begin
            key(4'h1); key(4'h2); key(4'h3); key(4'hF);
        end
        check("sat_subcnt", {24'd0, sub_cnt}, 32'd255);
        key(4'h4); key(4'h5); key(4'h6); key(4'hF);
        check("sat_rdy",     {31'd0, num_rdy}, 32'd1);
        check("sat_num",     {20'd0, num1, num2, num3}, 32'h456);
        check("sat_subcnt2", {24'd0, sub_cnt}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
